// File: rtl/pts.sv
// Parallel-to-serial frame converter: captures a 16-word frame and streams it out one beat per transfer.
// Optional PTS_BITREV_EN: beats are emitted in bit-reversed buffer order (FFT natural ordering).
module pts (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [31:0] in_d0,
    input  logic [31:0] in_d1,
    input  logic [31:0] in_d2,
    input  logic [31:0] in_d3,
    input  logic [31:0] in_d4,
    input  logic [31:0] in_d5,
    input  logic [31:0] in_d6,
    input  logic [31:0] in_d7,
    input  logic [31:0] in_d8,
    input  logic [31:0] in_d9,
    input  logic [31:0] in_d10,
    input  logic [31:0] in_d11,
    input  logic [31:0] in_d12,
    input  logic [31:0] in_d13,
    input  logic [31:0] in_d14,
    input  logic [31:0] in_d15,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_d,
    output logic [3:0]  out_idx,
    output logic        out_last,
    input  logic        out_ready,
    output logic        ovf
);
    localparam int NUM_WORDS = 16;
    localparam int VEC_W     = 32;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                              state_q, state_d;
    logic [3:0]                          cnt_q, cnt_d;
    logic [NUM_WORDS-1:0][VEC_W-1:0]     frame_q;
    logic [NUM_WORDS-1:0][VEC_W-1:0]     din;
    logic                                capture, xfer;

    assign din = {in_d15, in_d14, in_d13, in_d12, in_d11, in_d10, in_d9, in_d8,
                  in_d7,  in_d6,  in_d5,  in_d4,  in_d3,  in_d2,  in_d1, in_d0};

    // A new frame may land on the same edge the last beat of the current one leaves.
    assign in_ready  = (state_q == IDLE) || ((cnt_q == 4'd15) && out_ready);
    assign out_valid = (state_q == SEND);
    assign capture   = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (capture) begin
            state_d = SEND;
            cnt_d   = 4'd0;
        end else if (xfer) begin
            if (cnt_q == 4'd15) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ovf     <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture)
                frame_q <= din;
            if (in_valid && !in_ready)
                ovf <= 1'b1;
        end
    end

`ifdef PTS_BITREV_EN
    assign out_idx = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]};
`else
    assign out_idx = cnt_q;
`endif

    assign out_d    = frame_q[out_idx];
    assign out_last = (cnt_q == 4'd15);

endmodule

// File: tb/tb_pts.sv
// Self-checking bench for pts: directed scenarios plus random traffic against a frame-level model.
module tb_pts;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] fr [16];
    logic        in_ready, out_valid, out_last, ovf;
    logic [31:0] out_d;
    logic [3:0]  out_idx;

    // Reference model: the frame in flight, the beat number within it, sticky overrun.
    logic [31:0] mbuf [16];
    int          mcnt;
    bit          mv, movf, fresh;
    int          order [16];
    int          checks = 0;
    int          passes = 0;

    always #5 CLK = ~CLK;

    pts dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid),
        .in_d0(fr[0]),   .in_d1(fr[1]),   .in_d2(fr[2]),   .in_d3(fr[3]),
        .in_d4(fr[4]),   .in_d5(fr[5]),   .in_d6(fr[6]),   .in_d7(fr[7]),
        .in_d8(fr[8]),   .in_d9(fr[9]),   .in_d10(fr[10]), .in_d11(fr[11]),
        .in_d12(fr[12]), .in_d13(fr[13]), .in_d14(fr[14]), .in_d15(fr[15]),
        .in_ready(in_ready), .out_valid(out_valid), .out_d(out_d),
        .out_idx(out_idx), .out_last(out_last), .out_ready(out_ready), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mv = 0; mcnt = 0; movf = 0; fresh = 1;
        for (int i = 0; i < 16; i++) mbuf[i] = '0;
    endtask

    task automatic load(input logic [31:0] base);
        for (int i = 0; i < 16; i++) fr[i] = base + 32'(i);
    endtask

    task automatic randframe();
        for (int i = 0; i < 16; i++) fr[i] = $urandom;
    endtask

    // One clock: drive, check outputs mid-cycle, then advance the model on the edge.
    task automatic step(input bit iv, input bit ordy, input bit rs);
        int  ei;
        bit  rdy;
        in_valid = iv; out_ready = ordy; RST = rs;
        @(negedge CLK);
        rdy = !mv || (mcnt == 15 && ordy);
`ifdef PTS_BITREV_EN
        ei = order[mcnt];
`else
        ei = mcnt;
`endif
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), 32'(mv));
        chk("ovf", 32'(ovf), 32'(movf));
        if (mv || fresh) begin
            chk("out_d", out_d, mbuf[ei]);
            chk("out_idx", 32'(out_idx), 32'(ei));
            chk("out_last", 32'(out_last), 32'(mcnt == 15));
        end
        @(posedge CLK);
        if (rs) model_reset();
        else begin
            if (iv && !rdy) movf = 1;
            if (iv && rdy) begin
                for (int i = 0; i < 16; i++) mbuf[i] = fr[i];
                mv = 1; mcnt = 0; fresh = 0;
            end else if (mv && ordy) begin
                if (mcnt == 15) mv = 0;
                else mcnt++;
            end
        end
        #1;
    endtask

    initial begin
        int  stall;
        bit  sent;
        order = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int i = 0; i < 16; i++) fr[i] = '0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();

        // reset state, then a single n+1 frame with out_ready held high
        step(0, 1, 0);
        chk("rst_out_d", out_d, 32'd0);
        load(32'd1);
        step(1, 1, 0);
        chk("beat0", out_d, 32'd1);
        for (int i = 0; i < 20; i++) step(0, 1, 0);

        // frame B offered on frame A's last beat: continuous stream
        load(32'h100);
        step(1, 1, 0);
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            if (mv && mcnt == 15 && !sent) begin
                load(32'h200); sent = 1; step(1, 1, 0);
            end else step(0, 1, 0);
        end

        // downstream stall of 3 cycles at beat 5 carrying -5
        randframe(); fr[5] = 32'hFFFF_FFFB;
        step(1, 1, 0);
        stall = 0;
        for (int i = 0; i < 40 && mv; i++) begin
            if (mcnt == 5 && stall < 3) begin
                step(0, 0, 0); stall++;
            end else step(0, 1, 0);
        end
        chk("stall_done", 32'(mv), 32'd0);

        // overrun offered during beat 3 is dropped and latches ovf
        randframe();
        step(1, 1, 0);
        sent = 0;
        for (int i = 0; i < 25; i++) begin
            if (mv && mcnt == 3 && !sent) begin
                randframe(); sent = 1; step(1, 1, 0);
            end else step(0, 1, 0);
        end
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // reset at beat 7 aborts the frame; a new frame starts at beat 0
        randframe();
        step(1, 1, 0);
        for (int i = 0; i < 30 && mcnt != 7; i++) step(0, 1, 0);
        step(0, 1, 1);
        chk("abort_cnt", 32'(out_idx), 32'd0);
        randframe();
        step(1, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            randframe();
            step(($urandom % 4) == 0, ($urandom % 4) != 0, ($urandom % 80) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
